// File: rtl/dmem_lsu_pkg.sv
// Shared types for the data-memory load/store unit.
//   dmem_size_t : access size encoding of the EX-MA register (11 acts as word)
//   lsu_state_t : LSU bus FSM states
//   ex_ma_reg_t : dmem-related fields of the EX-MA pipeline register
// Helpers compute the effective byte offset (misaligned offsets truncated)
// and detect misaligned half/word accesses.
package dmem_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE     = 2'b00,
    SZ_HALF     = 2'b01,
    SZ_WORD     = 2'b10,
    SZ_WORD_ALT = 2'b11
  } dmem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] dmem_data;
    logic        dmem_rd_en;
    logic        dmem_wr_en;
    dmem_size_t  dmem_size;
    logic        dmem_sign;
  } ex_ma_reg_t;

  // Byte offset actually used on the bus: halves drop bit 0, words use 0.
  function automatic logic [1:0] eff_off(input dmem_size_t size, input logic [1:0] off);
    logic [1:0] r;
    case (size)
      SZ_BYTE: r = off;
      SZ_HALF: r = {off[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic is_misaligned(input dmem_size_t size, input logic [1:0] off);
    logic r;
    case (size)
      SZ_BYTE: r = 1'b0;
      SZ_HALF: r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// lsu_align: combinational lane logic of the load/store unit.
//   st_size/st_off/st_data -> st_wstrb/st_wdata : store strobe and lane-replicated data
//   ld_size/ld_off/ld_sign/ld_rdata -> ld_data : load extraction and sign/zero extension
// Misaligned offsets are truncated to the natural alignment of the size.
module lsu_align
  import dmem_lsu_pkg::*;
(
  input  dmem_size_t  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  st_wstrb,
  output logic [31:0] st_wdata,
  input  dmem_size_t  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_sign,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [1:0]  st_eoff;
  logic [1:0]  ld_eoff;
  logic [31:0] ld_shift;

  always_comb begin
    st_eoff  = eff_off(st_size, st_off);
    st_wstrb = '0;
    st_wdata = '0;
    case (st_size)
      SZ_BYTE: begin
        st_wstrb = 4'b0001 << st_eoff;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_wstrb = 4'b0011 << st_eoff;
        st_wdata = {2{st_data[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = st_data;
      end
    endcase
  end

  always_comb begin
    ld_eoff  = eff_off(ld_size, ld_off);
    ld_shift = ld_rdata >> {ld_eoff, 3'b000};
    ld_data  = '0;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit beside the Memory Access stage of the RV32I pipeline.
// Takes the dmem fields of the EX-MA register, runs one valid/ready bus access
// per memory op and returns the aligned, extended load word to Write-Back,
// stalling the pipeline until the access completes.
//   ex_ma_i, squash_i, stall_i               : pipeline side inputs
//   dmem_req_o/we/addr/wdata/wstrb, ready_i  : request channel (registered, held until accepted)
//   dmem_rsp_valid_i, dmem_rdata_i           : response channel (sampled only in WAIT)
//   load_data_o, lsu_stall_o, misalign_o     : results to WB / hazard unit
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned half/word accesses issue no
// request and raise misalign_o; when undefined, offsets are truncated.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  ex_ma_reg_t        ex_ma_i,
  input  logic              squash_i,
  input  logic              stall_i,
  output logic              dmem_req_o,
  input  logic              dmem_ready_i,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [3:0]        dmem_wstrb_o,
  input  logic              dmem_rsp_valid_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic [31:0]       load_data_o,
  output logic              lsu_stall_o,
  output logic              misalign_o
);

  lsu_state_t        state_q, state_d;
  logic              req_q, we_q, discard_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       load_q;
  dmem_size_t        ld_size_q;
  logic [1:0]        ld_off_q;
  logic              ld_sign_q;

  logic              mem_op, trap, start, stall_raw;
  logic [3:0]        st_wstrb;
  logic [31:0]       st_wdata, ld_data;

  assign mem_op = ex_ma_i.valid & (ex_ma_i.dmem_rd_en | ex_ma_i.dmem_wr_en);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = rst_ni & (state_q == ST_IDLE) & mem_op & ~squash_i &
                is_misaligned(ex_ma_i.dmem_size, ex_ma_i.alu_result[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign start = (state_q == ST_IDLE) & mem_op & ~squash_i & ~trap;

  lsu_align u_align (
    .st_size  (ex_ma_i.dmem_size),
    .st_off   (ex_ma_i.alu_result[1:0]),
    .st_data  (ex_ma_i.dmem_data),
    .st_wstrb (st_wstrb),
    .st_wdata (st_wdata),
    .ld_size  (ld_size_q),
    .ld_off   (ld_off_q),
    .ld_sign  (ld_sign_q),
    .ld_rdata (dmem_rdata_i[31:0]),
    .ld_data  (ld_data)
  );

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_REQ;
          stall_raw = 1'b1;
        end
      end
      ST_REQ: begin
        stall_raw = 1'b1;
        // Acceptance wins over a same-cycle squash: the bus has already seen it.
        if (dmem_ready_i) state_d = ST_WAIT;
        else if (squash_i) state_d = ST_IDLE;
      end
      ST_WAIT: begin
        stall_raw = 1'b1;
        if (dmem_rsp_valid_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!stall_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      load_q    <= '0;
      ld_size_q <= SZ_BYTE;
      ld_off_q  <= '0;
      ld_sign_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            req_q     <= 1'b1;
            we_q      <= ex_ma_i.dmem_wr_en;
            addr_q    <= ADDR_W'({ex_ma_i.alu_result[31:2], 2'b00});
            wdata_q   <= DATA_W'(st_wdata);
            wstrb_q   <= st_wstrb;
            ld_size_q <= ex_ma_i.dmem_size;
            ld_off_q  <= ex_ma_i.alu_result[1:0];
            ld_sign_q <= ex_ma_i.dmem_sign;
            discard_q <= 1'b0;
          end else if (trap) begin
            load_q <= '0;
          end
        end
        ST_REQ: begin
          if (dmem_ready_i) begin
            req_q     <= 1'b0;
            discard_q <= squash_i;
          end else if (squash_i) begin
            req_q <= 1'b0;
          end
        end
        ST_WAIT: begin
          // A squash seen after acceptance lets the access finish but drops the result.
          if (dmem_rsp_valid_i) begin
            if (!we_q && !discard_q && !squash_i) load_q <= ld_data;
          end else if (squash_i) begin
            discard_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_wstrb_o = wstrb_q;
  assign load_data_o  = trap ? '0 : load_q;
  assign lsu_stall_o  = rst_ni & stall_raw;
  assign misalign_o   = trap;

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
Load/store unit for the RV32I 5-stage pipeline, sitting beside the Memory Access stage.
- Consumes the dmem fields of the EX-MA pipeline register: address (alu_result), store data, rd/wr enables, size, sign.
- Drives a valid/ready data-memory bus and returns the aligned, extended load word to the Write-Back stage.
- Stalls the pipeline through the hazard unit until the access completes.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (fixed to 32 for RV32I)

Ports:
clk  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
ex_ma_i  in  ex_ma_reg_t  EX-MA register (valid, alu_result, dmem_data, dmem_rd_en, dmem_wr_en, dmem_size, dmem_sign)
squash_i  in  1  hazard-unit squash of the MA instruction
stall_i  in  1  external pipeline stall
dmem_req_o  out  1  bus request valid
dmem_ready_i  in  1  bus accepts request
dmem_we_o  out  1  1 = store, 0 = load
dmem_addr_o  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
dmem_wdata_o  out  DATA_W  lane-replicated store data
dmem_wstrb_o  out  4  byte strobes
dmem_rsp_valid_i  in  1  response/ack
dmem_rdata_i  in  DATA_W  read data
load_data_o  out  32  extended load result to WB
lsu_stall_o  out  1  stall request to hazard unit
misalign_o  out  1  misaligned-access flag (feature only; tie 0 otherwise)

Behaviour:
- Mem op = ex_ma_i.valid & (dmem_rd_en | dmem_wr_en). dmem_rd_en and dmem_wr_en are never both set.
- dmem_size encoding: 00 byte, 01 half, 10 word, 11 treated as word. off = addr[1:0].
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: when a mem op is present and squash_i=0, register bus outputs and go to REQ.
  - REQ: dmem_req_o=1. All bus outputs hold stable until dmem_ready_i=1, then go to WAIT.
  - WAIT: dmem_rsp_valid_i is sampled only in this state. On it, capture load_data_o and go to DONE.
  - DONE: lsu_stall_o=0. Stay while stall_i=1; return to IDLE when stall_i=0.
- lsu_stall_o is combinational: 1 in IDLE with a new unsquashed mem op, 1 in REQ, 1 in WAIT, 0 otherwise.
- Minimum latency: 3 stall cycles (zero-wait ready, response one cycle after acceptance).
- Store alignment:
  - byte: wstrb = 0001<<off, wdata = {4{d[7:0]}}
  - half: wstrb = 0011<<off, wdata = {2{d[15:0]}}
  - word: wstrb = 1111, wdata = d
- Load extraction: r = rdata >> (8*off).
  - byte: sign- or zero-extend r[7:0] per dmem_sign.
  - half: sign- or zero-extend r[15:0] per dmem_sign.
  - word: r.
  - Store acks leave load_data_o unchanged.
- Squash:
  - In IDLE: no request is issued.
  - In REQ before acceptance: drop dmem_req_o the next cycle, return to IDLE.
  - After acceptance: the access completes; the result is discarded. Stores are never cancelled once accepted.
- Reset (rst_ni=0, any state, including mid-access): next edge gives IDLE and all outputs 0: req, we, addr, wdata, wstrb, load_data_o, lsu_stall_o, misalign_o. A stale dmem_rsp_valid_i arriving in IDLE is ignored.
- Without the optional feature, misaligned offsets are truncated: half uses off & 2'b10, word uses off = 0.

Optional Feature:
LSU_MISALIGN_TRAP_EN
- Defined: a half with addr[0]=1, or a word with addr[1:0]≠0, issues no bus request. misalign_o=1 for that cycle, lsu_stall_o=0, load_data_o=0.
- Undefined: the truncation rule above applies and misalign_o is tied 0.

Decomposition:
- Shared package (util): dmem_size_t enum, lsu_state_t enum, ex_ma_reg_t.
- Sub-module lsu_align: purely combinational store lane generation (wstrb, wdata) and load extract/extend. dmem_lsu holds the FSM and output registers.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF, ready immediate, rsp next cycle -> addr 0x100, wstrb 1111, wdata 0xDEADBEEF, we=1, lsu_stall_o high exactly 3 cycles.
- LB addr 0x203 signed, rdata 0x80FF1234 -> load_data_o 0xFFFFFF80; LBU same -> 0x00000080; addr_o 0x200.
- SH addr 0x102, data 0x0000ABCD -> wdata 0xABCDABCD, wstrb 1100. LH signed addr 0x102, rdata 0x80010000 -> 0xFFFF8001.
- dmem_ready_i held low 5 cycles -> req/addr/wdata/wstrb stable, stall held. squash_i asserted in REQ -> req drops next cycle, no write observed.
- rst_ni low during WAIT -> next cycle all outputs 0, state IDLE. rsp_valid_i pulse afterward does not change load_data_o.
- With LSU_MISALIGN_TRAP_EN, LW addr 0x101 -> misalign_o=1, dmem_req_o never asserted, lsu_stall_o=0.
